// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one outstanding word read at a time and queues
// returned instructions in a two-entry buffer feeding decode; handles redirects.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall_in,
    input  logic        br_taken_in,
    input  logic [31:0] br_target_in,
    output logic [31:0] ir_out,
    output logic [31:0] ir_pc_out,
    output logic        ir_valid_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] stale_addr_q, stale_addr_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    entry_t      buf_q [2];
    entry_t      buf_d [2];

    logic        pop;
    logic        tail_idx;
    logic [1:0]  count_after_pop;

    always_comb begin
        // NOTE: every _d gets its current value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        stale_addr_d = stale_addr_q;
        count_d      = count_q;
        head_d       = head_q;
        buf_d        = buf_q;

        pop             = (count_q != 2'd0) && !id_stall_in;
        count_after_pop = count_q - {1'b0, pop};
        tail_idx        = head_q ^ count_q[0];

        if (br_taken_in) begin
            // Redirect wins over everything: flush and refetch from the aligned target.
            count_d    = 2'd0;
            fetch_pc_d = {br_target_in[31:2], 2'b00};
            unique case (state_q)
                S_REQ: begin
                    if (imem_ack) begin
                        state_d = S_REQ;
                    end else begin
                        state_d      = S_DISCARD;
                        stale_addr_d = fetch_pc_q;
                    end
                end
                S_DISCARD: state_d = imem_ack ? S_REQ : S_DISCARD;
                default:   state_d = S_REQ;
            endcase
        end else begin
            if (pop) begin
                head_d  = ~head_q;
                count_d = count_after_pop;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (count_after_pop < 2'd2) state_d = S_REQ;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        buf_d[tail_idx] = '{instr: imem_rdata, pc: fetch_pc_q};
                        fetch_pc_d      = fetch_pc_q + 32'd4;
                        count_d         = count_after_pop + 2'd1;
                        state_d         = (count_after_pop == 2'd0) ? S_REQ : S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            stale_addr_q <= RESET_PC;
            count_q      <= 2'd0;
            head_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            stale_addr_q <= stale_addr_d;
            count_q      <= count_d;
            head_q       <= head_d;
        end
    end

    // NOTE: buffer storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign imem_req     = (state_q != S_IDLE);
    assign imem_addr    = (state_q == S_DISCARD) ? stale_addr_q : fetch_pc_q;
    assign ir_valid_out = (count_q != 2'd0);
    assign ir_out       = ir_valid_out ? buf_q[head_q].instr : 32'h0;
    assign ir_pc_out    = ir_valid_out ? buf_q[head_q].pc    : 32'h0;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the fetch address loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_ack  input  1  memory has returned imem_rdata this cycle.
REQ-007 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-008 id_stall_in  input  1  decode cannot accept; hold the current instruction.
REQ-009 br_taken_in  input  1  branch resolved taken; redirect fetch.
REQ-010 br_target_in  input  32  redirect address, valid with br_taken_in.
REQ-011 ir_out  output  32  instruction presented to decode, driving the control unit's instruction input.
REQ-012 ir_pc_out  output  32  address of ir_out.
REQ-013 ir_valid_out  output  1  ir_out holds a real fetched instruction.

Function
REQ-014 Two-entry instruction buffer (FIFO) of {instruction, pc}; count 0..2.
REQ-015 FSM states: IDLE (no request outstanding), REQ (request outstanding), DISCARD (outstanding request is stale after a redirect).
REQ-016 imem_req=1 in REQ and DISCARD, otherwise 0; imem_addr=fetch_pc in REQ, the stale address in DISCARD, and don't-care in IDLE.
REQ-017 imem_addr shall stay constant while imem_req=1 and imem_ack=0; at most one request shall be outstanding.
REQ-018 IDLE->REQ when count after this cycle's pop is <2 and br_taken_in=0.
REQ-019 REQ with imem_ack=1: push {imem_rdata, fetch_pc}, fetch_pc+=4; stay in REQ if the buffer still has room after this push/pop, else IDLE.
REQ-020 Zero-wait memory (ack in the same cycle as req) sustains one instruction per cycle.
REQ-021 Buffer head drives ir_out/ir_pc_out with ir_valid_out=1; empty buffer -> ir_out=32'h0 (NOP), ir_pc_out=0, ir_valid_out=0.
REQ-022 Pop when ir_valid_out=1 and id_stall_in=0; under stall, ir_out and ir_pc_out are held unchanged.
REQ-023 Push and pop in the same cycle are allowed at count 1 or 2; count is unchanged.
REQ-024 br_taken_in=1 has priority over ack, stall and pop: flush the buffer (count=0); fetch_pc={br_target_in[31:2],2'b00}; ir_valid_out=0 and ir_out=0 next cycle.
REQ-025 Redirect in REQ with imem_ack=0 -> DISCARD; in DISCARD, the acked data shall be dropped, then the FSM moves to REQ at the new fetch_pc.
REQ-026 Redirect in REQ with imem_ack=1 -> the returned word is dropped; the FSM goes to REQ at the target.
REQ-027 Redirect in IDLE -> REQ at the target next cycle.
REQ-028 A second redirect while in DISCARD updates fetch_pc only; the single stale ack is still dropped.
REQ-029 imem_ack while in IDLE shall be ignored.
REQ-030 fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC+4 -> 0).

Reset
REQ-031 rst_n=0 at a clock edge sets: fetch_pc=RESET_PC, count=0, state IDLE, imem_req=0, ir_out=0, ir_pc_out=0, ir_valid_out=0.
REQ-032 Reset mid-request abandons the outstanding request; an ack arriving afterwards while in IDLE is ignored per REQ-029.
REQ-033 The first request is issued in the first cycle after rst_n rises (IDLE->REQ), at address RESET_PC.

Verification
REQ-034 Zero-wait memory returns word at addr A = A^32'h5A5A0000, no stall -> ir_out sequence 5A5A0000, 5A5A0004, 5A5A0008..., with ir_valid_out=1 from the 2nd cycle after the first request.
REQ-035 Same memory, id_stall_in=1 for 4 cycles -> ir_out held; count saturates at 2; imem_req drops to 0; no instruction lost or duplicated after release.
REQ-036 3-cycle ack latency; br_taken_in=1, target 32'h0000_0103, one cycle after the request -> stale word dropped; next imem_addr=32'h100; ir_out=0 until the word at 0x100 arrives.
REQ-037 Redirect coincident with imem_ack and id_stall_in -> buffer flushed, acked word dropped, ir_valid_out=0 next cycle, fetch resumes at the target.
REQ-038 rst_n=0 while REQ is outstanding, then released -> outputs are zero during reset; a late ack is ignored; the first post-reset imem_addr=RESET_PC.
REQ-039 RESET_PC=32'hFFFF_FFF8, zero-wait memory -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
